facing_controller: RTL and testbench

Sequences sprite facing for both fighters once per video frame. Replaces free-running facing comparison with a registered per-player turn state machine that applies a positional deadband. It blocks turns while a fighter is busy (attacking/jumping) and runs a fixed-length turn animation window before committing the new direction. Sits between the game-logic position registers and the sprite renderer/animation selector.

---
 rtl/facing_pkg.sv | 24 ++
 rtl/facing_fsm.sv | 79 +++++++
 rtl/facing_controller.sv | 73 +++++++
 tb/tb_facing_controller.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/facing_pkg.sv
// Shared types and constants for the per-fighter facing/turn sequencer.
package facing_pkg;

  typedef enum logic [1:0] {
    FACE_R = 2'b00,
    TURN_L = 2'b01,
    FACE_L = 2'b10,
    TURN_R = 2'b11
  } facing_state_t;

  localparam int CNT_W = 4;

  // Fighters start facing each other: P1 on the left looking right.
  localparam bit P1_RST_RIGHT = 1'b1;
  localparam bit P2_RST_RIGHT = 1'b0;

  localparam facing_state_t P1_RST_STATE = FACE_R;
  localparam facing_state_t P2_RST_STATE = FACE_L;

  function automatic facing_state_t rst_state(input bit rst_right);
    return rst_right ? FACE_R : FACE_L;
  endfunction

endpackage

// File: rtl/facing_fsm.sv
// One fighter's turn sequencer: deadband-qualified request, busy-gated start,
// fixed turn window, abort on reversal. Advances only on frame_tick.
module facing_fsm
  import facing_pkg::*;
#(
  parameter int TURN_FRAMES = 4,
  parameter bit RST_RIGHT   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  input  logic want_right,
  input  logic want_left,
  input  logic busy,
  output logic facing_right,
  output logic turning,
  output logic done
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TURN_FRAMES - 1);

  facing_state_t    state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= rst_state(RST_RIGHT);
      cnt          <= '0;
      facing_right <= RST_RIGHT;
      turning      <= 1'b0;
      done         <= 1'b0;
    end else begin
      // done is a single-clock pulse, independent of frame spacing
      done <= 1'b0;
      if (frame_tick) begin
        case (state)
          FACE_R: if (want_left && !busy) begin
            state   <= TURN_L;
            cnt     <= CNT_LOAD;
            turning <= 1'b1;
          end
          FACE_L: if (want_right && !busy) begin
            state   <= TURN_R;
            cnt     <= CNT_LOAD;
            turning <= 1'b1;
          end
          TURN_L: begin
            if (want_right) begin
              state   <= FACE_R;
              turning <= 1'b0;
            end else if (cnt == '0) begin
              state        <= FACE_L;
              facing_right <= 1'b0;
              turning      <= 1'b0;
              done         <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          TURN_R: begin
            if (want_left) begin
              state   <= FACE_L;
              turning <= 1'b0;
            end else if (cnt == '0) begin
              state        <= FACE_R;
              facing_right <= 1'b1;
              turning      <= 1'b0;
              done         <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: state <= rst_state(RST_RIGHT);
        endcase
      end
    end
  end

endmodule

// File: rtl/facing_controller.sv
// Per-frame facing sequencer for both fighters: deadband comparators feeding
// two independent turn FSMs.
module facing_controller
  import facing_pkg::*;
#(
  parameter int DEADBAND    = 2,
  parameter int TURN_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [6:0] p1_x,
  input  logic [6:0] p2_x,
  input  logic       p1_busy,
  input  logic       p2_busy,
  output logic       p1_facing_right,
  output logic       p2_facing_right,
  output logic       p1_turning,
  output logic       p2_turning,
  output logic [1:0] turn_done
);

  localparam int          NUM_LANES = 2;
  localparam logic [7:0]  DB        = 8'(DEADBAND);

  logic [NUM_LANES-1:0][6:0] pos;
  logic [NUM_LANES-1:0]      busy;
  logic [NUM_LANES-1:0]      want_right;
  logic [NUM_LANES-1:0]      want_left;
  logic [NUM_LANES-1:0]      facing_right;
  logic [NUM_LANES-1:0]      turning;
  logic [NUM_LANES-1:0]      done;

  assign pos  = {p2_x, p1_x};
  assign busy = {p2_busy, p1_busy};

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      logic [7:0] own;
      logic [7:0] opp;

      // 8-bit zero-extended so own+DEADBAND never wraps
      assign own = {1'b0, pos[i]};
      assign opp = (i == 0) ? {1'b0, pos[1]} : {1'b0, pos[0]};

      assign want_right[i] = (own + DB) < opp;
      assign want_left[i]  = own > (opp + DB);

      facing_fsm #(
        .TURN_FRAMES (TURN_FRAMES),
        .RST_RIGHT   ((i == 0) ? P1_RST_RIGHT : P2_RST_RIGHT)
      ) u_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .want_right   (want_right[i]),
        .want_left    (want_left[i]),
        .busy         (busy[i]),
        .facing_right (facing_right[i]),
        .turning      (turning[i]),
        .done         (done[i])
      );
    end
  endgenerate

  assign p1_facing_right = facing_right[0];
  assign p2_facing_right = facing_right[1];
  assign p1_turning      = turning[0];
  assign p2_turning      = turning[1];
  assign turn_done       = done;

endmodule

// File: tb/tb_facing_controller.sv
// Directed scoreboard bench for facing_controller (DEADBAND=2, TURN_FRAMES=4).
// Observed vector: {p1_facing_right, p2_facing_right, p1_turning, p2_turning, turn_done[1:0]}.
module tb_facing_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic [6:0] p1_x = 7'd10;
  logic [6:0] p2_x = 7'd80;
  logic       p1_busy = 1'b0;
  logic       p2_busy = 1'b0;
  logic       p1_facing_right, p2_facing_right, p1_turning, p2_turning;
  logic [1:0] turn_done;
  logic [5:0] obs;

  typedef struct {
    string      tag;
    logic [5:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  facing_controller #(
    .DEADBAND    (2),
    .TURN_FRAMES (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .frame_tick      (frame_tick),
    .p1_x            (p1_x),
    .p2_x            (p2_x),
    .p1_busy         (p1_busy),
    .p2_busy         (p2_busy),
    .p1_facing_right (p1_facing_right),
    .p2_facing_right (p2_facing_right),
    .p1_turning      (p1_turning),
    .p2_turning      (p2_turning),
    .turn_done       (turn_done)
  );

  assign obs = {p1_facing_right, p2_facing_right, p1_turning, p2_turning, turn_done};

  task automatic push(input string tag, input logic [5:0] v);
    exp_t x;
    x.tag = tag;
    x.val = v;
    sb.push_back(x);
  endtask

  task automatic check_pop();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %b expected <entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %b expected %b", e.tag, obs, e.val);
      end
    end
  endtask

  // One frame tick; checks the result edge and the following clock (done cleared, rest held).
  task automatic tick(input string tag, input logic [5:0] e);
    push(tag, e);
    push({tag, "_next"}, {e[5:2], 2'b00});
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    check_pop();
    @(negedge clk);
    check_pop();
  endtask

  // Clocks without a tick: nothing may move.
  task automatic idle(input string tag, input int n, input logic [5:0] e);
    push(tag, e);
    repeat (n) @(negedge clk);
    check_pop();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); rst_n = 1'b0;
    push(tag, 6'b10_00_00);
    #1 check_pop();
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    // reset hold and release, fighters already facing each other
    push("reset_hold", 6'b10_00_00);
    repeat (3) @(negedge clk);
    check_pop();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) tick("idle_facing", 6'b10_00_00);

    // crossing, but no tick: positions must not be acted on
    p1_x = 7'd60; p2_x = 7'd40;
    idle("no_tick_hold", 4, 6'b10_00_00);

    // simultaneous turn of both fighters
    tick("both_turn_k0", 6'b10_11_00);
    tick("both_turn_k1", 6'b10_11_00);
    tick("both_turn_k2", 6'b10_11_00);
    tick("both_turn_k3", 6'b10_11_00);
    tick("both_commit",  6'b01_00_11);
    tick("after_commit", 6'b01_00_00);

    // deadband boundaries
    do_reset("reset_db");
    p1_x = 7'd40; p2_x = 7'd41;
    tick("db_40_41", 6'b10_00_00);
    p1_x = 7'd42; p2_x = 7'd40;
    tick("db_42_40", 6'b10_00_00);
    p1_x = 7'd43; p2_x = 7'd40;
    tick("db_43_40_start", 6'b10_11_00);
    for (int k = 0; k < 3; k++) tick("db_turning", 6'b10_11_00);
    tick("db_commit", 6'b01_00_11);

    // busy blocks fighter 1 start only; mid-turn busy ignored
    do_reset("reset_busy");
    p1_x = 7'd60; p2_x = 7'd40; p1_busy = 1'b1;
    tick("busy_t1", 6'b10_01_00);
    tick("busy_t2", 6'b10_01_00);
    tick("busy_t3", 6'b10_01_00);
    p1_busy = 1'b0;
    tick("busy_drop_start", 6'b10_11_00);
    p1_busy = 1'b1;
    tick("p2_commit", 6'b11_10_10);
    tick("p1_busy_mid1", 6'b11_10_00);
    tick("p1_busy_mid2", 6'b11_10_00);
    tick("p1_commit", 6'b01_00_01);
    p1_busy = 1'b0;

    // abort at k+2
    do_reset("reset_abort");
    p1_x = 7'd60; p2_x = 7'd40;
    tick("abort_k0", 6'b10_11_00);
    tick("abort_k1", 6'b10_11_00);
    p1_x = 7'd10; p2_x = 7'd80;
    tick("abort_k2", 6'b10_00_00);
    tick("abort_k3", 6'b10_00_00);
    tick("abort_k4", 6'b10_00_00);

    // asynchronous reset mid-turn, away from any clock edge
    p1_x = 7'd60; p2_x = 7'd40;
    tick("pre_async", 6'b10_11_00);
    @(negedge clk);
    #2 rst_n = 1'b0;
    push("async_reset", 6'b10_00_00);
    #1 check_pop();
    @(negedge clk); rst_n = 1'b1;
    tick("post_async_restart", 6'b10_11_00);

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
